// File: rtl/mul_seq_32.sv
// rtl/mul_seq_32.sv - iterative unsigned 32x32->64 shift-and-add multiplier sequencer
//
// One add-and-shift step per clock through a single 33-bit adder, under a
// start/done handshake. Optional early termination is enabled by defining
// MUL_SEQ_EARLY_TERM_EN.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  request, sampled only while busy=0
//   a        in  32  multiplicand, captured on the accepting edge
//   b        in  32  multiplier, captured on the accepting edge
//   busy     out  1  high while an operation is running
//   done     out  1  one-cycle pulse, product valid
//   product  out 64  result, held until the next accepted start
module mul_seq_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;

  // Shared add stage: carry-in is tied to zero, carry-out lands in sum[32]
  // and is shifted into hi[31] so it is never lost.
  logic [32:0] addend;
  logic [32:0] sum;

  assign addend = lo_q[0] ? {1'b0, mcand_q} : 33'd0;
  assign sum    = {1'b0, hi_q} + addend;

`ifdef MUL_SEQ_EARLY_TERM_EN
  // After cnt steps, lo[31-cnt:0] still holds the unconsumed multiplier bits.
  // If they are all zero, {hi,lo} is the partial product shifted left by
  // (32-cnt); one right shift by that amount finishes the job.
  logic [31:0] rem_mask;
  logic        rem_zero;
  logic [6:0]  align_amt;
  logic [63:0] aligned;

  assign rem_mask  = 32'hFFFF_FFFF >> cnt_q;
  assign rem_zero  = ((lo_q & rem_mask) == 32'd0);
  assign align_amt = 7'd32 - {1'b0, cnt_q};
  assign aligned   = {hi_q, lo_q} >> align_amt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d = a;
          hi_d    = 32'd0;
          lo_d    = b;
          cnt_d   = 6'd0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 6'd1;
`ifdef MUL_SEQ_EARLY_TERM_EN
        if (rem_zero) begin
          {hi_d, lo_d} = aligned;
          state_d      = S_DONE;
        end else begin
          {hi_d, lo_d} = {sum, lo_q[31:1]};
          if (cnt_q == 6'd31) begin
            state_d = S_DONE;
          end
        end
`else
        {hi_d, lo_d} = {sum, lo_q[31:1]};
        if (cnt_q == 6'd31) begin
          state_d = S_DONE;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = {hi_q, lo_q};

endmodule

// File: tb/tb_mul_seq_32.sv
// tb/tb_mul_seq_32.sv - self-checking testbench for mul_seq_32
module tb_mul_seq_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int errors = 0;
  int checks = 0;

  mul_seq_32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  function automatic int exp_steps(input logic [31:0] bv);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int k;
    k = -1;
    for (int i = 0; i < 32; i++) begin
      if (bv[i]) k = i;
    end
    if (k < 0) return 1;
    return (k + 2 > 32) ? 32 : k + 2;
`else
    if (bv == 32'd0) return 32;
    return 32;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge. lat counts cycles
  // from the accept edge to the sample where done is seen.
  task automatic wait_done(input int inject_at, output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (lat == inject_at) begin
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp);
    int lat;
    int bc;
    int st;
    st = exp_steps(bv);
    accept(av, bv);
    wait_done(0, lat, bc);
    check({name, " product"}, product, exp);
    check({name, " latency"}, 64'(lat), 64'(st + 1));
    check({name, " busy_cycles"}, 64'(bc), 64'(st));
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    int bc;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h1234_5678,  32'd0,          64'd0};
    vecs[3] = '{32'd0,          32'h8000_0000,  64'd0};
    vecs[4] = '{32'h8000_0001,  32'h8000_0001,  64'h4000_0001_0000_0001};
    vecs[5] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
    vecs[6] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
    vecs[7] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
    vecs[8] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[9] = '{32'd7,          32'd9,          64'd63};

    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // Start during busy is ignored; start in the DONE cycle is accepted.
    accept(32'd3, 32'd5);
    check("run busy", 64'(busy), 64'd1);
    wait_done(10, lat, bc);
    check("ignored start product", product, 64'd15);
    check("ignored start latency", 64'(lat), 64'(exp_steps(32'd5) + 1));
    a     = 32'd7;
    b     = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b done drops", 64'(done), 64'd0);
    check("b2b busy", 64'(busy), 64'd1);
    wait_done(0, lat, bc);
    check("b2b product", product, 64'd63);
    check("b2b latency", 64'(lat), 64'(exp_steps(32'd9) + 1));
    repeat (3) @(negedge clk);
    check("hold product", product, 64'd63);
    check("hold done low", 64'(done), 64'd0);

    // Asynchronous reset mid-run, away from any clock edge.
    accept(32'h8000_0001, 32'h8000_0001);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    check("async rst product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post reset", 32'h8000_0001, 32'h8000_0001, 64'h4000_0001_0000_0001);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", i), ra, rb, 64'(ra) * 64'(rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
